w0rm_core_writeback: RTL and testbench
======================================

# w0rm_core_writeback

Writeback stage of the W0RM core: the write-side driver of the register file's write port. Collects results from the ALU and the memory unit through valid/ready handshakes, arbitrates round-robin when both present a result, and registers the winner onto the register file's write port. Optionally exposes the registered write as a forwarding tap so register fetch can bypass the write-before-read window.

## Interface
- DATA_WIDTH, 32, result and write-data width
- NUM_REGISTERS, 16, register count; ADDR_WIDTH = log2(NUM_REGISTERS)
- USER_WIDTH, 1, sideband carried alongside each result, returned unmodified

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_addr  in  ADDR_WIDTH  destination register
- alu_data  in  DATA_WIDTH  result
- alu_user  in  USER_WIDTH  sideband
- mem_valid / mem_ready / mem_addr / mem_data / mem_user: same as ALU port, memory unit source
- rf_ready  in  1  register file accepts the write this cycle
- port_write_enable  out  1  write strobe to register file
- port_write_addr  out  ADDR_WIDTH  write address
- port_write_data  out  DATA_WIDTH  write data
- user_data_out  out  USER_WIDTH  sideband of the current write
- fwd_valid  out  1  forwarding tap valid
- fwd_addr  out  ADDR_WIDTH  forwarding address
- fwd_data  out  DATA_WIDTH  forwarding data

## Operation
- One output register (out_valid, addr, data, user) drives port_write_*; port_write_enable = out_valid.
- Output stage "can load" = !out_valid | rf_ready.
- Arbitration (combinational): only one source valid -> it wins; both valid -> source other than last_grant wins.
- x_ready = can_load & grant_x & !flush & reset deasserted. At most one ready high per cycle.
- On a handshake: output register loads winner's addr/data/user, out_valid <= 1, last_grant <= winner.
- out_valid & rf_ready & no handshake -> out_valid <= 0; addr/data/user hold last values.
- rf_ready low with out_valid high -> all outputs hold, both readies low.
- flush: out_valid <= 0 next edge, readies low during flush cycle, last_grant unchanged.
- No address filtering: every address, including 0, is written.
- Sideband passes through untouched; widths never truncated or extended.

## Timing
- Reset (asynchronous, reset low): out_valid 0, port_write_addr 0, port_write_data 0, user_data_out 0, fwd_* 0, last_grant = MEM (ALU wins first contention); alu_ready/mem_ready forced 0 while reset low.
- Latency: result accepted at edge N appears on port_write_* from N to N+1, written into register file at edge N+1 if rf_ready.
- Throughput: one write per cycle with rf_ready held high; back-to-back handshakes on consecutive cycles legal.
- Contention with both valid every cycle: grants alternate ALU, MEM, ALU, ...
- Flush and handshake in same cycle: flush wins, no accept.
- Reset mid-stall: pending write discarded, no write strobe after reset release until a new handshake.
- Inputs must hold valid/addr/data/user stable until ready; the block never samples without ready.

## Configuration
- W0RM_WRITEBACK_FORWARD_EN defined: fwd_valid = out_valid, fwd_addr = port_write_addr, fwd_data = port_write_data (same cycle as the write strobe), letting register fetch substitute data when its read address matches.
- Undefined: fwd_valid, fwd_addr, fwd_data tied to 0; no forwarding logic synthesized. Port list identical in both builds.

## Structure
- Shared header w0rm_core_defs.vh: log2 function, source-select encoding (SRC_ALU = 0, SRC_MEM = 1), reset-value constants.
- One sub-module: w0rm_rr_arbiter2, two-request round-robin arbiter holding last_grant; inputs req[1:0], advance; output one-hot grant[1:0].
- Top level holds the output register, handshake gating, flush and forwarding logic.

## Test plan
DATA_WIDTH 8, NUM_REGISTERS 4, rf_ready 1 unless stated.
- ALU only: alu addr 2, data 0x5A valid one cycle -> alu_ready 1 that cycle; next cycle write_enable 1, addr 2, data 0x5A; then enable 0.
- Contention: both valid for 4 cycles, ALU (1, 0x11), MEM (3, 0x33) -> grants ALU, MEM, ALU, MEM; write stream 0x11, 0x33, 0x11, 0x33.
- Backpressure: write pending addr 1 data 0xC3, rf_ready low 3 cycles -> outputs hold 0xC3, both readies 0; rf_ready high -> one write, next source accepted same edge.
- Flush: MEM valid and flush high same cycle -> mem_ready 0; pending write cleared, enable 0 next cycle.
- Async reset: reset low mid-stall with write pending -> enable, addr, data, fwd_* 0 immediately, no write after release until a new handshake.
- Forwarding (macro defined): ALU addr 0 data 0xFF -> fwd_valid 1, fwd_addr 0, fwd_data 0xFF same cycle as write strobe; macro undefined -> fwd_* stay 0.

Source files
------------

// File: rtl/w0rm_core_writeback_pkg.sv
// Shared definitions for the W0RM writeback stage: source encoding, reset constants, log2 helper.
package w0rm_core_writeback_pkg;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // ALU wins the first contention after reset because MEM is recorded as last served.
  localparam src_e RESET_LAST_GRANT = SRC_MEM;
  localparam logic RESET_OUT_VALID  = 1'b0;

  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/w0rm_core_writeback_if.sv
// Result source handshake bundle (valid/ready plus destination, data and sideband).
interface w0rm_core_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int USER_WIDTH = 1
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;

  modport master (output valid, output addr, output data, output user, input ready);
  modport slave  (input valid, input addr, input data, input user, output ready);
endinterface

// File: rtl/w0rm_core_writeback_arbiter.sv
// Two-request round-robin arbiter; last_grant advances only when a grant is actually taken.
module w0rm_rr_arbiter2
  import w0rm_core_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  src_e last_grant_reg;
  src_e last_grant_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= RESET_LAST_GRANT;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    grant           = 2'b00;
    last_grant_next = last_grant_reg;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_reg == SRC_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (advance) begin
      last_grant_next = grant[1] ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/w0rm_core_writeback.sv
// W0RM writeback stage: arbitrates ALU/MEM results onto the register file write port.
// Build option: W0RM_WRITEBACK_FORWARD_EN exposes the registered write as a forwarding tap.
module w0rm_core_writeback
  import w0rm_core_writeback_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_REGISTERS = 16,
  parameter  int USER_WIDTH    = 1,
  localparam int ADDR_WIDTH    = log2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  w0rm_core_writeback_if.slave  alu,
  w0rm_core_writeback_if.slave  mem,
  input  logic                  rf_ready,
  output logic                  port_write_enable,
  output logic [ADDR_WIDTH-1:0] port_write_addr,
  output logic [DATA_WIDTH-1:0] port_write_data,
  output logic [USER_WIDTH-1:0] user_data_out,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  can_load;
  logic                  accept_open;
  logic                  handshake;

  logic                  out_valid_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [USER_WIDTH-1:0] user_reg;

  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [USER_WIDTH-1:0] win_user;

  assign req         = {mem.valid, alu.valid};
  assign can_load    = !out_valid_reg || rf_ready;
  // Reset in the gate keeps both readies low for the whole time reset is held.
  assign accept_open = can_load && !flush && reset;
  assign alu.ready   = accept_open && grant[0];
  assign mem.ready   = accept_open && grant[1];
  assign handshake   = alu.ready || mem.ready;

  w0rm_rr_arbiter2 u_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (handshake),
    .grant   (grant)
  );

  always_comb begin
    win_addr = alu.addr;
    win_data = alu.data;
    win_user = alu.user;
    if (grant[1]) begin
      win_addr = mem.addr;
      win_data = mem.data;
      win_user = mem.user;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= RESET_OUT_VALID;
      addr_reg      <= '0;
      data_reg      <= '0;
      user_reg      <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (handshake) begin
      out_valid_reg <= 1'b1;
      addr_reg      <= win_addr;
      data_reg      <= win_data;
      user_reg      <= win_user;
    end else if (rf_ready) begin
      // Payload holds after the write drains; only the strobe drops.
      out_valid_reg <= 1'b0;
    end
  end

  assign port_write_enable = out_valid_reg;
  assign port_write_addr   = addr_reg;
  assign port_write_data   = data_reg;
  assign user_data_out     = user_reg;

`ifdef W0RM_WRITEBACK_FORWARD_EN
  assign fwd_valid = out_valid_reg;
  assign fwd_addr  = addr_reg;
  assign fwd_data  = data_reg;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Self-checking bench for w0rm_core_writeback: directed scenarios then random traffic vs a queue model.
module tb_w0rm_core_writeback;
  import w0rm_core_writeback_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int UW = 1;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          rf_ready = 1'b1;
  logic          port_write_enable;
  logic [AW-1:0] port_write_addr;
  logic [DW-1:0] port_write_data;
  logic [UW-1:0] user_data_out;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  w0rm_core_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) alu_if ();
  w0rm_core_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) mem_if ();

  w0rm_core_writeback #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .USER_WIDTH(UW)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .alu               (alu_if),
    .mem               (mem_if),
    .rf_ready          (rf_ready),
    .port_write_enable (port_write_enable),
    .port_write_addr   (port_write_addr),
    .port_write_data   (port_write_data),
    .user_data_out     (user_data_out),
    .fwd_valid         (fwd_valid),
    .fwd_addr          (fwd_addr),
    .fwd_data          (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } wr_t;

  // Model: results accepted but not yet written, the last loaded payload, and who was served last.
  wr_t  exp_wr[$];
  wr_t  held;
  src_e m_last;
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  bit   g_alu_acc;
  bit   g_mem_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_wr.delete();
    held   = '0;
    m_last = SRC_MEM;
  endtask

  task automatic drive(input bit sel_mem, input bit v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [UW-1:0] u);
    if (sel_mem) begin
      mem_if.valid = v; mem_if.addr = a; mem_if.data = d; mem_if.user = u;
    end else begin
      alu_if.valid = v; alu_if.addr = a; alu_if.data = d; alu_if.user = u;
    end
  endtask

  // One clock: check at the falling edge, then advance the model just after the rising edge.
  task automatic step();
    bit  ea, em, can, exp_en;
    wr_t cur, won;
    @(negedge clk);
    exp_en = (exp_wr.size() != 0);
    cur    = exp_en ? exp_wr[0] : held;
    can    = !exp_en || rf_ready;
    ea = 1'b0;
    em = 1'b0;
    if (reset && can && !flush) begin
      if (alu_if.valid && mem_if.valid) begin
        if (m_last == SRC_MEM) ea = 1'b1; else em = 1'b1;
      end else if (alu_if.valid) begin
        ea = 1'b1;
      end else if (mem_if.valid) begin
        em = 1'b1;
      end
    end
    check("alu_ready", alu_if.ready, ea);
    check("mem_ready", mem_if.ready, em);
    check("wr_en", port_write_enable, exp_en);
    check("wr_addr", port_write_addr, cur.addr);
    check("wr_data", port_write_data, cur.data);
    check("wr_user", user_data_out, cur.user);
`ifdef W0RM_WRITEBACK_FORWARD_EN
    check("fwd_valid", fwd_valid, exp_en);
    check("fwd_addr", fwd_addr, exp_en ? cur.addr : held.addr);
    check("fwd_data", fwd_data, exp_en ? cur.data : held.data);
`else
    check("fwd_valid", fwd_valid, 1'b0);
    check("fwd_addr", fwd_addr, '0);
    check("fwd_data", fwd_data, '0);
`endif
    if (ea) won = '{addr: alu_if.addr, data: alu_if.data, user: alu_if.user};
    else    won = '{addr: mem_if.addr, data: mem_if.data, user: mem_if.user};
    @(posedge clk);
    #1;
    if (exp_en && rf_ready && reset) begin
      void'(exp_wr.pop_front());
      writes++;
    end
    if (flush) exp_wr.delete();
    if (ea || em) begin
      exp_wr.push_back(won);
      held   = won;
      m_last = em ? SRC_MEM : SRC_ALU;
    end
    if (!reset) model_reset();
    g_alu_acc = ea;
    g_mem_acc = em;
  endtask

  initial begin
    model_reset();
    drive(0, 1, 2'd1, 8'hAA, 1'b1);
    drive(1, 0, 2'd0, 8'h00, 1'b0);
    // Held in reset with a valid source: readies and outputs stay zero.
    step();
    step();
    reset = 1'b1;
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    step();

    // ALU only.
    drive(0, 1, 2'd2, 8'h5A, 1'b1);
    step();
    check("alu_only_acc", g_alu_acc, 1'b1);
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    // Contention from a fresh reset: ALU first, then alternating.
    reset = 1'b0;
    #1;
    model_reset();
    reset = 1'b1;
    drive(0, 1, 2'd1, 8'h11, 1'b0);
    drive(1, 1, 2'd3, 8'h33, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("contend_mem_grant", g_mem_acc, (i % 2));
      check("contend_alu_grant", g_alu_acc, ((i + 1) % 2));
    end
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    drive(1, 0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    // Backpressure with a pending write and a waiting MEM result.
    drive(0, 1, 2'd1, 8'hC3, 1'b0);
    step();
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    drive(1, 1, 2'd2, 8'h77, 1'b1);
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_data", port_write_data, 8'hC3);
    end
    rf_ready = 1'b1;
    step();
    check("stall_release_acc", g_mem_acc, 1'b1);
    drive(1, 0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    // Flush with a pending write and MEM valid in the same cycle.
    drive(0, 1, 2'd3, 8'h4E, 1'b0);
    rf_ready = 1'b0;
    step();
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    drive(1, 1, 2'd0, 8'h81, 1'b1);
    flush = 1'b1;
    step();
    check("flush_no_acc", g_mem_acc, 1'b0);
    flush = 1'b0;
    drive(1, 0, 2'd0, 8'h00, 1'b0);
    step();
    rf_ready = 1'b1;
    step();

    // Asynchronous reset while a write is stalled.
    drive(0, 1, 2'd3, 8'h9C, 1'b1);
    rf_ready = 1'b0;
    step();
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("arst_en", port_write_enable, 1'b0);
    check("arst_addr", port_write_addr, '0);
    check("arst_data", port_write_data, '0);
    check("arst_fwd_valid", fwd_valid, 1'b0);
    check("arst_fwd_data", fwd_data, '0);
    model_reset();
    rf_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    step();

    // Forwarding tap on a write to register 0.
    drive(0, 1, 2'd0, 8'hFF, 1'b0);
    step();
    drive(0, 0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    // Random traffic; sources hold their result until accepted.
    for (int n = 0; n < 2000; n++) begin
      if (g_alu_acc || !alu_if.valid)
        drive(0, ($urandom % 100) < 60, AW'($urandom), DW'($urandom), UW'($urandom));
      if (g_mem_acc || !mem_if.valid)
        drive(1, ($urandom % 100) < 60, AW'($urandom), DW'($urandom), UW'($urandom));
      flush    = ($urandom % 100) < 8;
      rf_ready = ($urandom % 100) < 75;
      step();
    end
    check("writes_seen", (writes > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
